// File: rtl/ex_wb_stage_pkg.sv
// Shared CPU definitions for the execute/writeback stage: opcodes, flag
// bit positions in the {C,Z,N,V} status register, and stage states.
package ex_wb_stage_pkg;

  localparam logic [5:0] OP_AND  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ANDI = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_BGT  = 6'd8;
  localparam logic [5:0] OP_BLT  = 6'd9;
  localparam logic [5:0] OP_BEQ  = 6'd10;
  localparam logic [5:0] OP_BNE  = 6'd11;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {ST_RUN, ST_SHADOW} state_e;

  function automatic logic is_alu(input logic [5:0] op);
    return op <= OP_ADDI;
  endfunction

  // Arithmetic ops are the only ones that produce meaningful C and V.
  function automatic logic is_arith(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ex_wb_stage_branch_cond.sv
// Branch decode and condition evaluation from the ALU flags of the beat.
module branch_cond
  import ex_wb_stage_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_negative,
  input  logic       i_overflow,
  output logic       o_is_branch,
  output logic       o_cond
);

  always_comb begin
    o_is_branch = 1'b1;
    o_cond      = 1'b0;
    case (i_opcode)
      OP_BEQ:  o_cond = i_zero;
      OP_BNE:  o_cond = !i_zero;
      OP_BLT:  o_cond = i_negative != i_overflow;
      OP_BGT:  o_cond = !i_zero && (i_negative == i_overflow);
      default: o_is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: registers ALU results toward the register file,
// keeps the status flags, resolves branches and drops wrong-path beats.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int SHADOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_result,
  input  logic        carry,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  output logic [3:0]  flags_q,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam int CW = (SHADOW_CYCLES < 1) ? 1 : $clog2(SHADOW_CYCLES + 1);

  state_e          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_out_valid, r_out_wr_en, r_br_taken, r_illegal;
  logic [31:0]     r_out_result, r_br_target;
  logic [4:0]      r_out_rd;
  logic [3:0]      r_flags;

  logic w_accept, w_run_acc, w_alu, w_is_br, w_cond, w_ill, w_take, w_load;

  branch_cond u_branch_cond (
    .i_opcode    (opcode),
    .i_zero      (zero),
    .i_negative  (negative),
    .i_overflow  (overflow),
    .o_is_branch (w_is_br),
    .o_cond      (w_cond)
  );

  // Wrong-path beats are swallowed unconditionally so the fetch side never stalls on them.
  assign in_ready  = (r_state == ST_SHADOW) ? 1'b1 : (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_run_acc = w_accept && (r_state == ST_RUN);
  assign w_alu     = is_alu(opcode);
  assign w_ill     = !w_alu && !w_is_br;
  assign w_take    = w_run_acc && w_is_br && w_cond;
  assign w_load    = w_run_acc && (w_alu || w_ill);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_take && (SHADOW_CYCLES != 0)) begin
          w_state_n = ST_SHADOW;
          w_cnt_n   = CW'(SHADOW_CYCLES);
        end
      end
      ST_SHADOW: begin
        if (w_accept) begin
          w_cnt_n = r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) w_state_n = ST_RUN;
        end
      end
      default: w_state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_wr_en  <= 1'b0;
      r_flags      <= '0;
      r_br_taken   <= 1'b0;
      r_br_target  <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_out_valid <= w_load || (r_out_valid && !out_ready);
      if (w_load) begin
        r_out_result <= alu_result;
        r_out_rd     <= rd;
        r_out_wr_en  <= w_alu;
      end
      if (w_run_acc && w_alu) begin
        r_flags[FLAG_Z] <= zero;
        r_flags[FLAG_N] <= negative;
        if (is_arith(opcode)) begin
          r_flags[FLAG_C] <= carry;
          r_flags[FLAG_V] <= overflow;
        end
      end else if (w_run_acc && w_is_br) begin
        r_flags[FLAG_C] <= carry;
        r_flags[FLAG_Z] <= zero;
        r_flags[FLAG_N] <= negative;
        r_flags[FLAG_V] <= overflow;
      end
      r_br_taken <= w_take;
      if (w_take) r_br_target <= pc + imm;
      r_illegal  <= w_run_acc && w_ill;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_wr_en  = r_out_wr_en;
  assign flags_q    = r_flags;
  assign br_taken   = r_br_taken;
  assign br_target  = r_br_target;
  assign illegal    = r_illegal;

endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 SHALL have parameter SHADOW_CYCLES, default 2, number of wrong-path beats discarded after a taken branch.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU beat present.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- opcode  in  6  opcode driven to the ALU for this beat.
- alu_result  in  32  ALU result.
- carry, zero, negative, overflow  in  1 each  ALU flags.
- pc  in  32  instruction address.
- imm  in  32  sign-extended branch offset.
- rd  in  5  destination register.
- out_valid  out  1  writeback beat held.
- out_ready  in  1  register-file side accepts.
- out_result  out  32  registered result.
- out_rd  out  5  registered destination.
- out_wr_en  out  1  write enable for the held beat.
- flags_q  out  4  {C,Z,N,V} status register.
- br_taken  out  1  one-cycle redirect pulse.
- br_target  out  32  redirect address, valid with br_taken.
- illegal  out  1  one-cycle pulse, unknown opcode accepted.

Function
REQ-003 SHALL drive in_ready = !out_valid || out_ready in state RUN, and 1 in state SHADOW.
REQ-004 SHALL recognise AND=0, ADD=1, SUB=2, ANDI=3, ADDI=4, BGT=8, BLT=9, BEQ=10, BNE=11; all other opcodes are unknown.
REQ-005 SHALL, on an accepted ALU op (0-4) in RUN, load out_result=alu_result, out_rd=rd, out_wr_en=1, out_valid=1 at the next edge (latency 1).
REQ-006 SHALL hold out_* stable while out_valid && !out_ready; out_valid clears on handshake unless a new beat loads the same edge.
REQ-007 SHALL update flags_q on accepted ALU ops in RUN: Z,N always; C,V only for ADD, SUB, ADDI; AND/ANDI leave C,V unchanged.
REQ-008 SHALL evaluate branches from input flags: BEQ zero; BNE !zero; BLT negative!=overflow; BGT !zero && negative==overflow.
REQ-009 SHALL, on an accepted branch in RUN, not load the output register, set flags_q {C,Z,N,V} from inputs, and, if the condition holds, pulse br_taken with br_target=pc+imm (mod 2^32) the next cycle.
REQ-010 SHALL implement states RUN and SHADOW: taken branch in RUN -> SHADOW with shadow counter = SHADOW_CYCLES; SHADOW -> RUN when counter reaches 0 on an accepted beat.
REQ-011 SHALL, in SHADOW, discard every accepted beat (no output load, no flag update, no br_taken, no illegal), decrementing the counter once per accepted beat.
REQ-012 SHALL, if SHADOW_CYCLES=0, remain in RUN after a taken branch.
REQ-013 SHALL, on an accepted unknown opcode in RUN, load the output with out_wr_en=0, leave flags_q unchanged, and pulse illegal.
REQ-014 SHALL let a pending output drain in SHADOW; draining is independent of discarding.

Reset
REQ-015 SHALL, when rst_n=0 at a rising edge, set out_valid=0, out_result=0, out_rd=0, out_wr_en=0, flags_q=0, br_taken=0, br_target=0, illegal=0, state RUN, counter 0.
REQ-016 SHALL let reset override all activity, including mid-SHADOW and held backpressured beats, which are lost.

Structure
REQ-017 SHALL take opcode constants, flag bit indices {C=3,Z=2,N=1,V=0}, and the state enum from the shared CPU package.
REQ-018 SHALL place branch-condition evaluation (REQ-008) in a combinational sub-module branch_cond.

Verification
REQ-019 ADD, alu_result=0x80000000, C=0, Z=0, N=1, V=1, rd=5 -> next cycle out_valid=1, out_result=0x80000000, out_rd=5, flags_q=4'b0011.
REQ-020 BEQ, zero=1, pc=0x100, imm=0x20 -> br_taken pulse, br_target=0x120; next 2 accepted ADDs dropped; third ADD writes back.
REQ-021 BLT, negative=1, overflow=1 -> no br_taken, no output beat, state stays RUN.
REQ-022 out_ready=0 with out_valid=1 -> in_ready=0, out_* stable 3 cycles; out_ready=1 -> drain and accept same edge.
REQ-023 opcode=6'h3F accepted -> illegal pulse, out_wr_en=0, flags_q unchanged.
REQ-024 rst_n=0 one cycle while in SHADOW with out_valid=1 -> all outputs 0, next ADD processed in RUN.
